// File: rtl/escaner_display_9999.sv
// escaner_display_9999: 14-bit binary to 4-digit BCD (shift-add-3) and multiplexed 7-seg digit scan.
// Latency: load at edge N, busy N..N+14, display registers updated at edge N+15, pins one cycle later.
// Backpressure: cargar is only accepted in IDLE/ACTUALIZA; strobes while converting are dropped.
// Ports: clk, rst (sync, active-high); valor/cargar load a value; ocupado flags a conversion;
//        codigo_decoder feeds the shared BCD decoder; anodos are active-low digit enables (bit0 = units).
module escaner_display_9999 #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] valor,
  input  logic        cargar,
  output logic        ocupado,
  output logic [3:0]  codigo_decoder,
  output logic [3:0]  anodos
);

  typedef enum logic [1:0] {IDLE, CONVIERTE, ACTUALIZA} estado_t;

  localparam logic [19:0] DIV_MAX = 20'(SCAN_DIV - 1);

  estado_t          estado;
  logic [13:0]      bin;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [3:0]       cnt;
  logic             ovf;
  logic [3:0][3:0]  dig;
  logic [19:0]      div;
  logic [1:0]       idx;
  logic [3:0]       blank;
  logic             captura;

  // A new load is taken in IDLE and also in the single ACTUALIZA cycle, so
  // back-to-back conversions lose no cycle.
  assign captura = cargar && (estado == IDLE || estado == ACTUALIZA);

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion FSM; display registers are written in one cycle so the scan
  // never shows a mix of old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      dig     <= '0;
      ocupado <= 1'b0;
    end else begin
      case (estado)
        IDLE: ;
        CONVIERTE: begin
          bcd <= {bcd_adj[14:0], bin[13]};
          bin <= {bin[12:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13) estado <= ACTUALIZA;
        end
        ACTUALIZA: begin
          dig     <= ovf ? 16'hFFFF : bcd;
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
        default: estado <= IDLE;
      endcase
      if (captura) begin
        bin     <= valor;
        bcd     <= '0;
        cnt     <= '0;
        ovf     <= (valor > 14'd9999);
        ocupado <= 1'b1;
        estado  <= CONVIERTE;
      end
    end
  end

  // Slot k>0 goes dark when it and every higher digit are zero; 4'hF is
  // non-zero, so error digits always stay lit.
  always_comb begin
    blank = 4'b0000;
    if (BLANK_LZ) begin
      blank[3] = (dig[3] == 4'd0);
      blank[2] = blank[3] && (dig[2] == 4'd0);
      blank[1] = blank[2] && (dig[1] == 4'd0);
    end
  end

  // Scan divider, index and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div            <= '0;
      idx            <= '0;
      anodos         <= 4'b1111;
      codigo_decoder <= 4'hF;
    end else begin
      if (div == DIV_MAX) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 20'd1;
      end
      if (blank[idx]) begin
        anodos         <= 4'b1111;
        codigo_decoder <= 4'hF;
      end else begin
        anodos         <= ~(4'b0001 << idx);
        codigo_decoder <= dig[idx];
      end
    end
  end

endmodule

// File: tb/tb_escaner_display_9999.sv
// tb_escaner_display_9999: directed checks of conversion, scan, blanking, overflow and reset.
// Two instances (leading-zero blanking on and off) share the same stimulus, SCAN_DIV=4.
// Expected displayed values are queued at load time and popped when the display is checked.
module tb_escaner_display_9999;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] valor;
  logic        cargar;
  logic        ocupado, ocupado_nb;
  logic [3:0]  codigo, codigo_nb;
  logic [3:0]  anodos, anodos_nb;

  int ncmp = 0;
  int nerr = 0;
  int k    = 0;    // cycles since reset release, for the expected scan index
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  escaner_display_9999 #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .valor(valor), .cargar(cargar),
    .ocupado(ocupado), .codigo_decoder(codigo), .anodos(anodos)
  );

  escaner_display_9999 #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_nb (
    .clk(clk), .rst(rst), .valor(valor), .cargar(cargar),
    .ocupado(ocupado_nb), .codigo_decoder(codigo_nb), .anodos(anodos_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] digit_of(input int v, input int i);
    int d = v;
    if (v > 9999) return 4'hF;
    for (int j = 0; j < i; j++) d = d / 10;
    return 4'(d % 10);
  endfunction

  // Expected {anodos, codigo} of slot i for displayed value v.
  function automatic logic [7:0] slot_exp(input int v, input int i, input bit blank_lz);
    bit all_zero = 1'b1;
    for (int j = i; j < 4; j++) if (digit_of(v, j) != 4'd0) all_zero = 1'b0;
    if (blank_lz && i > 0 && all_zero) return 8'hFF;
    return {~(4'b0001 << i), digit_of(v, i)};
  endfunction

  // Pops the expected value and checks both instances for ncyc cycles.
  task automatic check_disp(input int ncyc);
    int v;
    int i;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 16'd1, 16'd0);
      return;
    end
    v = exp_q.pop_front();
    for (int c = 0; c < ncyc; c++) begin
      i = ((k - 1) / 4) % 4;
      chk($sformatf("disp_%0d_slot%0d", v, i), {anodos, codigo}, slot_exp(v, i, 1'b1));
      chk($sformatf("disp_nb_%0d_slot%0d", v, i), {anodos_nb, codigo_nb}, slot_exp(v, i, 1'b0));
      step();
    end
  endtask

  // Count busy cycles from the current sample point, bounded.
  task automatic wait_idle(output int busy);
    busy = 0;
    while (ocupado && busy < 40) begin
      busy++;
      step();
    end
  endtask

  // Full load: strobe, busy-length check, then one edge so pins show the new value.
  task automatic do_load(input int v);
    int busy;
    valor  = 14'(v);
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    exp_q.push_back(v);
    wait_idle(busy);
    chk($sformatf("busy_len_%0d", v), 16'(busy), 16'd15);
    step();
  endtask

  initial begin
    int busy;
    rst    = 1'b1;
    valor  = '0;
    cargar = 1'b0;
    step();
    step();
    chk("rst_anodos", 16'(anodos), 16'hF);
    chk("rst_codigo", 16'(codigo), 16'hF);
    chk("rst_ocupado", 16'(ocupado), 16'd0);
    rst = 1'b0;
    step();
    chk("post_rst_anodos", 16'(anodos), 16'hE);
    chk("post_rst_codigo", 16'(codigo), 16'h0);
    chk("post_rst_ocupado", 16'(ocupado), 16'd0);
    exp_q.push_back(0);
    check_disp(16);

    do_load(1234);
    check_disp(16);
    do_load(7);
    check_disp(16);
    do_load(10000);
    check_disp(16);
    do_load(9999);
    check_disp(16);
    do_load(0);
    check_disp(16);
    do_load(16383);
    check_disp(8);

    // Strobe at +5 ignored, strobe at +15 accepted.
    valor  = 14'd1234;
    cargar = 1'b1;
    step();                         // edge N
    cargar = 1'b0;
    exp_q.push_back(1234);
    repeat (4) step();              // after N+4
    valor  = 14'd5678;
    cargar = 1'b1;
    step();                         // edge N+5, dropped
    cargar = 1'b0;
    chk("ignored_busy", 16'(ocupado), 16'd1);
    repeat (9) step();              // after N+14
    chk("busy_at_n14", 16'(ocupado), 16'd1);
    valor  = 14'd5678;
    cargar = 1'b1;
    step();                         // edge N+15, accepted
    cargar = 1'b0;
    exp_q.push_back(5678);
    chk("reload_busy", 16'(ocupado), 16'd1);
    step();                         // after N+16: pins show 1234
    check_disp(1);
    wait_idle(busy);
    chk("reload_busy_len", 16'(busy), 16'd13);
    step();
    check_disp(16);

    // Reset in the middle of a conversion.
    valor  = 14'd4321;
    cargar = 1'b1;
    step();
    cargar = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ocupado", 16'(ocupado), 16'd0);
    chk("midrst_anodos", 16'(anodos), 16'hF);
    step();
    chk("midrst_idx0", {anodos, codigo}, 16'hE0);
    exp_q.push_back(0);
    check_disp(16);
    chk("midrst_idle", 16'(ocupado), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
